uart_rx_stream: RTL and testbench
=================================

Name: uart_rx_stream

Overview:
UART 8N1 receiver that deserialises the line the SoC's UART transmitter drives (uart_tx_o). It buffers received bytes in a small FIFO and presents them on a valid/ready byte stream. It is used as the bench-side/loopback receiver for system_top, and as the RX datapath for a later UART peripheral revision. Single clock domain; the serial input is asynchronous to it.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (truncating), HALF = CLKS_PER_BIT/2; CLKS_PER_BIT must be >= 4
FIFO_DEPTH, 8, byte FIFO entries; power of 2, >= 2

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
rx_i  input  1  serial line, idle high, asynchronous to clk_in
rx_data_o  output  8  FIFO head byte; reads 8'h00 when FIFO is empty
rx_valid_o  output  1  FIFO non-empty
rx_ready_i  input  1  consumer accepts the head byte when rx_valid_o && rx_ready_i
frame_err_o  output  1  1-cycle pulse: stop bit sampled low
overrun_o  output  1  1-cycle pulse: completed byte dropped because the FIFO was full
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset values: all pointers, counters and fifo_count_o = 0; FSM = IDLE; rx_valid_o/frame_err_o/overrun_o/busy_o = 0; rx_data_o = 0. The 2-FF synchroniser resets to 1. FIFO memory contents are not reset.
- rx_i passes through a 2-FF synchroniser to produce rx_s. All sampling uses rx_s.
- FSM states: IDLE, START, DATA, STOP, BREAK. A single bit counter cnt runs in each state.
- IDLE: rx_s==0 -> START, cnt=0.
- START: when cnt==HALF-1, sample rx_s. If 0 -> DATA, cnt=0, bit_idx=0. If 1 -> IDLE; treat it as a glitch: no error, no data.
- DATA: when cnt==CLKS_PER_BIT-1, sample rx_s into the shift register (LSB first: shift right, insert at bit 7), reset cnt, increment bit_idx. After the 8th sample -> STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1 -> push the byte to the FIFO, go to IDLE. The FSM returns at mid-stop-bit so that a back-to-back start edge is caught.
  - 0 -> pulse frame_err_o, discard the byte, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line must produce no further bytes or errors.
- FIFO is first-word-fall-through: rx_valid_o = (count != 0); rx_data_o = mem[rd_ptr] when valid, else 0.
- Pop occurs on rx_valid_o && rx_ready_i.
- A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overrun_o pulses in the push cycle.
- Simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Latency: a pushed byte is visible (rx_valid_o=1) the cycle after the stop-sample cycle. Measured from the rx_i falling edge, this is 2 + HALF + 9*CLKS_PER_BIT + 1 clocks, ±1 clock for synchroniser phase.
- busy_o = (state != IDLE), combinational from the state register.
- frame_err_o and overrun_o never assert in the same cycle, because a framing error never pushes.
- Reset mid-frame: the FSM abandons the frame immediately and the FIFO empties. After reset release, the first falling edge is treated as a new start bit.

Test Plan (CLK_FREQ=1000000, BAUD=100000 -> CLKS_PER_BIT=10, HALF=5; FIFO_DEPTH=4 unless noted):
1. Send 0xA5 with rx_ready_i=1 -> rx_valid_o high for exactly 1 cycle with rx_data_o=0xA5, about 98 clocks after the start edge. frame_err_o and overrun_o stay 0. busy_o returns to 0.
2. Send 0x00, 0xFF, 0x3C back-to-back with rx_ready_i=0 -> fifo_count_o=3. Then set rx_ready_i=1 -> the bytes pop in order 0x00, 0xFF, 0x3C on consecutive cycles, then rx_data_o=0x00 and rx_valid_o=0.
3. Drive rx_i low for 3 clocks, then high -> busy_o pulses and returns to 0 after HALF+2 clocks. No byte is pushed and no error pulses.
4. Send 0x55 with a low stop bit, then hold the line low for 40 clocks, then high, then send 0x12 -> exactly one frame_err_o pulse and no byte for 0x55. 0x12 is then received correctly.
5. Send 5 bytes 0x01..0x05 with rx_ready_i=0 -> fifo_count_o=4 and a single overrun_o pulse at the 5th stop sample. Drain yields 0x01..0x04. Repeat with rx_ready_i pulsed in the 5th byte's stop-sample cycle -> no overrun, and 0x05 is retained.
6. Assert rst_n=0 during DATA bit 4 of 0xC3, with 2 bytes queued -> all outputs at reset values and fifo_count_o=0. After release, send 0x81 -> 0x81 is received cleanly.

Source files
------------

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM and a
// first-word-fall-through byte FIFO presented as a valid/ready stream.
module uart_rx_stream #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;

  // ---------------------------------------------------------------- sync
  logic rx_meta, rx_s;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       sh, sh_nx;
  logic             push_req, frame_err;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      sh      <= sh_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    sh_nx      = sh;
    push_req   = 1'b0;
    frame_err  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        // Start bit re-checked at mid-bit; a high line here was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx   = S_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx     = '0;
          sh_nx      = {rx_s, sh[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        // Leaving at mid-stop-bit keeps a back-to-back start edge visible.
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            push_req = 1'b1;
            state_nx = S_IDLE;
          end else begin
            frame_err = 1'b1;
            state_nx  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_nx = '0;
        if (rx_s) state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state != S_IDLE);
  assign frame_err_o = frame_err;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop, push_ok;

  assign rx_valid_o   = (count != '0);
  assign rx_data_o    = rx_valid_o ? mem[rd_ptr] : 8'h00;
  assign fifo_count_o = count;
  assign pop          = rx_valid_o && rx_ready_i;
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign push_ok      = push_req && ((count < DEPTH_C) || pop);
  assign overrun_o    = push_req && !push_ok;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: 10 clocks per bit, 4-entry FIFO.
module tb_uart_rx_stream;

  localparam int CPB  = 10;
  localparam int HALF = 5;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_i   = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       frame_err_o;
  logic       overrun_o;
  logic [2:0] fifo_count_o;
  logic       busy_o;

  uart_rx_stream #(
    .CLK_FREQ   (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .fifo_count_o (fifo_count_o),
    .busy_o       (busy_o)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // passive monitor, sampled on the falling edge
  int         cyc = 0;
  int         rise_cyc = 0, ov_cyc = 0;
  int         valid_cnt = 0, fe_cnt = 0, ov_cnt = 0, both_cnt = 0, busy_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] pop_q [$];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (rx_valid_o && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid_o;
    if (rx_valid_o) valid_cnt++;
    if (rx_valid_o && rx_ready_i) pop_q.push_back(rx_data_o);
    if (frame_err_o) fe_cnt++;
    if (overrun_o) begin ov_cnt++; ov_cyc = cyc; end
    if (frame_err_o && overrun_o) both_cnt++;
    if (busy_o) busy_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1,
                           input logic ready_pulse = 1'b0);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i = stop_bit;
    for (int i = 0; i < CPB; i++) begin
      if (ready_pulse && i == 7) rx_ready_i = 1'b1;
      if (ready_pulse && i == 8) rx_ready_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_i = 1'b1; rx_ready_i = 1'b0;
    repeat (3) tick();
    checks++; if (fifo_count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data_o); end
    checks++; if ({busy_o, frame_err_o, overrun_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy_o, frame_err_o, overrun_o}); end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int c0, v0, f0, o0, q0;
    rx_ready_i = 1'b1;
    v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt; q0 = pop_q.size();
    c0 = cyc;
    send_byte(8'hA5);
    repeat (10) tick();
    checks++; if (rise_cyc - c0 < 97 || rise_cyc - c0 > 99) begin errors++; $display("FAIL single_latency got %0d exp 98+-1", rise_cyc - c0); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", valid_cnt - v0); end
    checks++; if (pop_q.size() - q0 !== 1) begin errors++; $display("FAIL single_pops got %0d exp 1", pop_q.size() - q0); end
    else begin
      checks++; if (pop_q[q0] !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", pop_q[q0]); end
    end
    checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin errors++; $display("FAIL single_err got fe %0d ov %0d exp 0 0", fe_cnt - f0, ov_cnt - o0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    int q0;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    rx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
    repeat (5) tick();
    checks++; if (fifo_count_o !== 3'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", fifo_count_o); end
    checks++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h00) begin errors++; $display("FAIL b2b_head got v%b %h exp v1 00", rx_valid_o, rx_data_o); end
    q0 = pop_q.size();
    rx_ready_i = 1'b1;
    repeat (3) tick();
    rx_ready_i = 1'b0;
    checks++; if (pop_q.size() - q0 !== 3) begin errors++; $display("FAIL b2b_pops got %0d exp 3", pop_q.size() - q0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (pop_q[q0+i] !== exp_b[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h exp %h", i, pop_q[q0+i], exp_b[i]); end
      end
    end
    checks++; if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || fifo_count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty got v%b %h c%0d exp v0 00 c0", rx_valid_o, rx_data_o, fifo_count_o); end
  endtask

  task automatic test_glitch();
    int b0, f0, v0, n;
    b0 = busy_cnt; f0 = fe_cnt; v0 = valid_cnt;
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b exp 1", busy_o); end
    n = 0;
    while (busy_o !== 1'b0 && n < 20) begin tick(); n++; end
    checks++; if (n == 0 || n > HALF + 2) begin errors++; $display("FAIL glitch_busy_return got %0d clocks exp 1..%0d", n, HALF + 2); end
    checks++; if (busy_cnt - b0 < HALF - 1 || busy_cnt - b0 > HALF + 2) begin errors++; $display("FAIL glitch_busy_len got %0d exp about %0d", busy_cnt - b0, HALF); end
    repeat (5) tick();
    checks++; if (fe_cnt - f0 !== 0 || valid_cnt - v0 !== 0 || fifo_count_o !== 3'd0) begin errors++; $display("FAIL glitch_nodata got fe %0d v %0d c %0d exp 0 0 0", fe_cnt - f0, valid_cnt - v0, fifo_count_o); end
  endtask

  task automatic test_frame_err();
    int f0, o0, q0;
    f0 = fe_cnt; o0 = ov_cnt; q0 = pop_q.size();
    rx_ready_i = 1'b1;
    send_byte(8'h55, 1'b0);
    repeat (40) tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ferr_break_busy got %b exp 1", busy_o); end
    rx_i = 1'b1;
    repeat (20) tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_break_exit got %b exp 0", busy_o); end
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", fe_cnt - f0); end
    checks++; if (pop_q.size() - q0 !== 0) begin errors++; $display("FAIL ferr_nobyte got %0d exp 0", pop_q.size() - q0); end
    send_byte(8'h12);
    repeat (10) tick();
    checks++; if (pop_q.size() - q0 !== 1) begin errors++; $display("FAIL ferr_recover_pops got %0d exp 1", pop_q.size() - q0); end
    else begin
      checks++; if (pop_q[q0] !== 8'h12) begin errors++; $display("FAIL ferr_recover_data got %h exp 12", pop_q[q0]); end
    end
    checks++; if (fe_cnt - f0 !== 1 || ov_cnt - o0 !== 0 || both_cnt !== 0) begin errors++; $display("FAIL ferr_flags got fe %0d ov %0d both %0d exp 1 0 0", fe_cnt - f0, ov_cnt - o0, both_cnt); end
    rx_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    int o0, q0, c5;
    // Part 1: fifth byte dropped
    o0 = ov_cnt;
    rx_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    c5 = cyc;
    send_byte(8'h05);
    repeat (5) tick();
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ov_cnt - o0); end
    checks++; if (ov_cyc - c5 !== 97) begin errors++; $display("FAIL ovr_timing got %0d exp 97", ov_cyc - c5); end
    checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL ovr_count got %0d exp 4", fifo_count_o); end
    q0 = pop_q.size();
    rx_ready_i = 1'b1;
    repeat (4) tick();
    rx_ready_i = 1'b0;
    checks++; if (pop_q.size() - q0 !== 4) begin errors++; $display("FAIL ovr_drain got %0d exp 4", pop_q.size() - q0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (pop_q[q0+i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain[%0d] got %h exp %h", i, pop_q[q0+i], 8'(i + 1)); end
      end
    end
    // Part 2: pop in the push cycle rescues the fifth byte
    o0 = ov_cnt;
    q0 = pop_q.size();
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_byte(8'h05, 1'b1, 1'b1);
    repeat (5) tick();
    checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_rescue_pulses got %0d exp 0", ov_cnt - o0); end
    checks++; if (fifo_count_o !== 3'd4) begin errors++; $display("FAIL ovr_rescue_count got %0d exp 4", fifo_count_o); end
    rx_ready_i = 1'b1;
    repeat (4) tick();
    rx_ready_i = 1'b0;
    checks++; if (pop_q.size() - q0 !== 5) begin errors++; $display("FAIL ovr_rescue_drain got %0d exp 5", pop_q.size() - q0); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (pop_q[q0+i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_rescue[%0d] got %h exp %h", i, pop_q[q0+i], 8'(i + 1)); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int f0, o0, q0;
    logic [7:0] b;
    b = 8'hC3;
    rx_ready_i = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (5) tick();
    checks++; if (fifo_count_o !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 2", fifo_count_o); end
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (CPB) tick();
    end
    rx_i = b[4];
    repeat (5) tick();
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_count_o !== 3'd0 || rx_valid_o !== 1'b0 || rx_data_o !== 8'h00) begin errors++; $display("FAIL rstmid_fifo got c%0d v%b %h exp c0 v0 00", fifo_count_o, rx_valid_o, rx_data_o); end
    checks++; if ({busy_o, frame_err_o, overrun_o} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", {busy_o, frame_err_o, overrun_o}); end
    rx_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    f0 = fe_cnt; o0 = ov_cnt; q0 = pop_q.size();
    rx_ready_i = 1'b1;
    send_byte(8'h81);
    repeat (10) tick();
    checks++; if (pop_q.size() - q0 !== 1) begin errors++; $display("FAIL rstmid_pops got %0d exp 1", pop_q.size() - q0); end
    else begin
      checks++; if (pop_q[q0] !== 8'h81) begin errors++; $display("FAIL rstmid_data got %h exp 81", pop_q[q0]); end
    end
    checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0 || fifo_count_o !== 3'd0) begin errors++; $display("FAIL rstmid_clean got fe %0d ov %0d c %0d exp 0 0 0", fe_cnt - f0, ov_cnt - o0, fifo_count_o); end
    rx_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
